// File: rtl/id_ex_pipeline_stage_pkg.sv
// Shared widths, control-bundle type and hazard helper for the ID/EX stage.
package leg_pipe_pkg;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 5;
  localparam int ALUOP_W = 4;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  typedef struct packed {
    logic               regWrite;
    logic               memRead;
    logic               memWrite;
    logic               aluSrc;
    logic [ALUOP_W-1:0] aluOp;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // True when a producer writing wa should supply the value of source register src.
  // XZR is never a match, so its read always stays the register-file zero.
  function automatic logic producerHits(input logic we,
                                        input logic [ADDR_W-1:0] wa,
                                        input logic [ADDR_W-1:0] src);
    return we && (wa == src) && (src != ZERO_REG);
  endfunction

endpackage

// File: rtl/id_ex_pipeline_stage_if.sv
// Bus between decode/forwarding sources and the ID/EX register.
interface id_ex_pipeline_stage_if;
  import leg_pipe_pkg::*;

  logic                id_valid;
  logic [ADDR_W-1:0]   readAddress1;
  logic [ADDR_W-1:0]   readAddress2;
  logic [DATA_W-1:0]   regData1;
  logic [DATA_W-1:0]   regData2;
  logic [ADDR_W-1:0]   writeAddress;
  logic [DATA_W-1:0]   id_imm;
  logic                id_regWrite;
  logic                id_memRead;
  logic                id_memWrite;
  logic                id_aluSrc;
  logic [ALUOP_W-1:0]  id_aluOp;
  logic                flush;
  logic                mem_regWrite;
  logic [ADDR_W-1:0]   mem_writeAddress;
  logic [DATA_W-1:0]   mem_result;
  logic                wb_regWrite;
  logic [ADDR_W-1:0]   wb_writeAddress;
  logic [DATA_W-1:0]   wb_writeData;
  logic                stall;
  logic                ex_valid;
  logic                ex_regWrite;
  logic                ex_memRead;
  logic                ex_memWrite;
  logic                ex_aluSrc;
  logic [ALUOP_W-1:0]  ex_aluOp;
  logic [ADDR_W-1:0]   ex_writeAddress;
  logic [DATA_W-1:0]   ex_imm;
  logic [DATA_W-1:0]   ex_operandA;
  logic [DATA_W-1:0]   ex_storeData;
  logic [DATA_W-1:0]   ex_operandB;

  modport master (
    output id_valid, readAddress1, readAddress2, regData1, regData2, writeAddress,
           id_imm, id_regWrite, id_memRead, id_memWrite, id_aluSrc, id_aluOp, flush,
           mem_regWrite, mem_writeAddress, mem_result,
           wb_regWrite, wb_writeAddress, wb_writeData,
    input  stall, ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_aluOp,
           ex_writeAddress, ex_imm, ex_operandA, ex_storeData, ex_operandB
  );

  modport slave (
    input  id_valid, readAddress1, readAddress2, regData1, regData2, writeAddress,
           id_imm, id_regWrite, id_memRead, id_memWrite, id_aluSrc, id_aluOp, flush,
           mem_regWrite, mem_writeAddress, mem_result,
           wb_regWrite, wb_writeAddress, wb_writeData,
    output stall, ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_aluOp,
           ex_writeAddress, ex_imm, ex_operandA, ex_storeData, ex_operandB
  );

endinterface

// File: rtl/id_ex_pipeline_stage_forward_select.sv
// Priority operand mux: EX/MEM result, then MEM/WB data, then the captured value.
module forward_select
  import leg_pipe_pkg::*;
(
  input  logic [ADDR_W-1:0] src,
  input  logic [DATA_W-1:0] captured,
  input  logic              memRegWrite,
  input  logic [ADDR_W-1:0] memWriteAddress,
  input  logic [DATA_W-1:0] memResult,
  input  logic              wbRegWrite,
  input  logic [ADDR_W-1:0] wbWriteAddress,
  input  logic [DATA_W-1:0] wbWriteData,
  output logic [DATA_W-1:0] operand
);

  // Newest producer wins; with no producer match the captured operand passes through.
  always_comb begin
    operand = captured;
    if (producerHits(memRegWrite, memWriteAddress, src)) begin
      operand = memResult;
    end else if (producerHits(wbRegWrite, wbWriteAddress, src)) begin
      operand = wbWriteData;
    end
  end

endmodule

// File: rtl/id_ex_pipeline_stage.sv
// ID/EX pipeline register with capture bypass, operand forwarding and load-use stall.
module id_ex_pipeline_stage (
  input logic CLOCK,
  input logic RESET,
  id_ex_pipeline_stage_if.slave bus
);
  import leg_pipe_pkg::*;

  logic              exValid;
  ctrl_t             exCtrl;
  logic [ADDR_W-1:0] exWriteAddress;
  logic [DATA_W-1:0] exImm;
  logic [DATA_W-1:0] capA;
  logic [DATA_W-1:0] capB;
  logic [ADDR_W-1:0] srcA;
  logic [ADDR_W-1:0] srcB;

  logic              loadUse;
  ctrl_t             idCtrl;
  logic [DATA_W-1:0] bypassA;
  logic [DATA_W-1:0] bypassB;
  logic [DATA_W-1:0] operandA;
  logic [DATA_W-1:0] storeData;

  // Decode-side view: gated control, same-cycle write-through and load-use detection.
  always_comb begin
    idCtrl = CTRL_BUBBLE;
    if (bus.id_valid) begin
      idCtrl.regWrite = bus.id_regWrite;
      idCtrl.memRead  = bus.id_memRead;
      idCtrl.memWrite = bus.id_memWrite;
      idCtrl.aluSrc   = bus.id_aluSrc;
      idCtrl.aluOp    = bus.id_aluOp;
    end
    bypassA = producerHits(bus.wb_regWrite, bus.wb_writeAddress, bus.readAddress1)
              ? bus.wb_writeData : bus.regData1;
    bypassB = producerHits(bus.wb_regWrite, bus.wb_writeAddress, bus.readAddress2)
              ? bus.wb_writeData : bus.regData2;
    loadUse = exValid && exCtrl.memRead && (exWriteAddress != ZERO_REG) && bus.id_valid &&
              ((exWriteAddress == bus.readAddress1) || (exWriteAddress == bus.readAddress2));
  end

  // Stage register: reset, then flush/stall bubble, otherwise capture decode.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      exValid        <= 1'b0;
      exCtrl         <= CTRL_BUBBLE;
      exWriteAddress <= '0;
      exImm          <= '0;
      capA           <= '0;
      capB           <= '0;
      srcA           <= '0;
      srcB           <= '0;
    end else if (bus.flush || loadUse) begin
      exValid        <= 1'b0;
      exCtrl         <= CTRL_BUBBLE;
      exWriteAddress <= ZERO_REG;
      exImm          <= '0;
      capA           <= '0;
      capB           <= '0;
      srcA           <= ZERO_REG;
      srcB           <= ZERO_REG;
    end else begin
      exValid        <= bus.id_valid;
      exCtrl         <= idCtrl;
      exWriteAddress <= bus.writeAddress;
      exImm          <= bus.id_imm;
      capA           <= bypassA;
      capB           <= bypassB;
      srcA           <= bus.readAddress1;
      srcB           <= bus.readAddress2;
    end
  end

  forward_select fwdA (
    .src             (srcA),
    .captured        (capA),
    .memRegWrite     (bus.mem_regWrite),
    .memWriteAddress (bus.mem_writeAddress),
    .memResult       (bus.mem_result),
    .wbRegWrite      (bus.wb_regWrite),
    .wbWriteAddress  (bus.wb_writeAddress),
    .wbWriteData     (bus.wb_writeData),
    .operand         (operandA)
  );

  forward_select fwdB (
    .src             (srcB),
    .captured        (capB),
    .memRegWrite     (bus.mem_regWrite),
    .memWriteAddress (bus.mem_writeAddress),
    .memResult       (bus.mem_result),
    .wbRegWrite      (bus.wb_regWrite),
    .wbWriteAddress  (bus.wb_writeAddress),
    .wbWriteData     (bus.wb_writeData),
    .operand         (storeData)
  );

  assign bus.stall           = loadUse;
  assign bus.ex_valid        = exValid;
  assign bus.ex_regWrite     = exCtrl.regWrite;
  assign bus.ex_memRead      = exCtrl.memRead;
  assign bus.ex_memWrite     = exCtrl.memWrite;
  assign bus.ex_aluSrc       = exCtrl.aluSrc;
  assign bus.ex_aluOp        = exCtrl.aluOp;
  assign bus.ex_writeAddress = exWriteAddress;
  assign bus.ex_imm          = exImm;
  assign bus.ex_operandA     = operandA;
  assign bus.ex_storeData    = storeData;
  assign bus.ex_operandB     = exCtrl.aluSrc ? exImm : storeData;

endmodule

// File: tb/tb_id_ex_pipeline_stage.sv
// Self-checking bench for the ID/EX stage: vector table, hazard sequences, random vs model.
module tb_id_ex_pipeline_stage;
  import leg_pipe_pkg::*;

  logic CLOCK = 1'b0;
  logic RESET;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 CLOCK = ~CLOCK;

  id_ex_pipeline_stage_if bus();

  id_ex_pipeline_stage dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct packed {
    logic        idValid;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [4:0]  wa;
    logic [63:0] imm;
    logic        regWrite;
    logic        memRead;
    logic        aluSrc;
    logic        flush;
    logic        memRW;
    logic [4:0]  memWA;
    logic [63:0] memRes;
    logic        wbRW;
    logic [4:0]  wbWA;
    logic [63:0] wbData;
    logic        expValid;
    logic        expRegWrite;
    logic        expMemRead;
    logic        expStall;
    logic [4:0]  expWa;
    logic        chkOps;
    logic [63:0] expA;
    logic [63:0] expB;
  } vecT;

  vecT tbl[8];
  vecT v;

  // Reference state: the instruction currently sitting in EX, as the spec describes it.
  logic        mValid, mRw, mMr, mMw, mAs;
  logic [3:0]  mOp;
  logic [4:0]  mWa;
  logic [63:0] mImm;
  logic [63:0] mVal[2];
  logic [4:0]  mSrc[2];
  logic        opsKnown, immKnown;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    bus.id_valid = 0; bus.readAddress1 = 0; bus.readAddress2 = 0;
    bus.regData1 = 0; bus.regData2 = 0; bus.writeAddress = 0; bus.id_imm = 0;
    bus.id_regWrite = 0; bus.id_memRead = 0; bus.id_memWrite = 0; bus.id_aluSrc = 0;
    bus.id_aluOp = 0; bus.flush = 0;
    bus.mem_regWrite = 0; bus.mem_writeAddress = 0; bus.mem_result = 0;
    bus.wb_regWrite = 0; bus.wb_writeAddress = 0; bus.wb_writeData = 0;
  endtask

  task automatic applyStimulus(input vecT s);
    clearInputs();
    bus.id_valid = s.idValid; bus.readAddress1 = s.ra1; bus.readAddress2 = s.ra2;
    bus.regData1 = s.rd1; bus.regData2 = s.rd2; bus.writeAddress = s.wa; bus.id_imm = s.imm;
    bus.id_regWrite = s.regWrite; bus.id_memRead = s.memRead; bus.id_aluSrc = s.aluSrc;
    bus.flush = s.flush;
    bus.mem_regWrite = s.memRW; bus.mem_writeAddress = s.memWA; bus.mem_result = s.memRes;
    bus.wb_regWrite = s.wbRW; bus.wb_writeAddress = s.wbWA; bus.wb_writeData = s.wbData;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #2;
  endtask

  function automatic logic [4:0] randReg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Value a reader of src sees: the newest in-flight producer of src, else the held value.
  function automatic logic [63:0] newestValue(input logic [4:0] src, input logic [63:0] held,
                                              input logic useMem);
    logic        we[2];
    logic [4:0]  dst[2];
    logic [63:0] val[2];
    we[0] = useMem && bus.mem_regWrite; dst[0] = bus.mem_writeAddress; val[0] = bus.mem_result;
    we[1] = bus.wb_regWrite;            dst[1] = bus.wb_writeAddress;  val[1] = bus.wb_writeData;
    if (src == 5'd31) return held;
    for (int p = 0; p < 2; p++) begin
      if (we[p] && dst[p] == src) return val[p];
    end
    return held;
  endfunction

  function automatic logic modelStall();
    return mValid && mMr && (mWa != 5'd31) && bus.id_valid &&
           (mWa == bus.readAddress1 || mWa == bus.readAddress2);
  endfunction

  task automatic modelEdge();
    logic st;
    st = modelStall();
    if (RESET) begin
      {mValid, mRw, mMr, mMw, mAs, mOp, mWa, mImm} = '0;
      opsKnown = 0; immKnown = 1;
    end else if (bus.flush || st) begin
      {mValid, mRw, mMr, mMw, mAs, mOp} = '0;
      mWa = 5'd31; opsKnown = 0; immKnown = 0;
    end else begin
      mValid = bus.id_valid;
      mRw = bus.id_valid & bus.id_regWrite;
      mMr = bus.id_valid & bus.id_memRead;
      mMw = bus.id_valid & bus.id_memWrite;
      mAs = bus.id_valid & bus.id_aluSrc;
      mOp = bus.id_valid ? bus.id_aluOp : 4'd0;
      mWa = bus.writeAddress; mImm = bus.id_imm;
      mSrc[0] = bus.readAddress1; mSrc[1] = bus.readAddress2;
      mVal[0] = newestValue(bus.readAddress1, bus.regData1, 1'b0);
      mVal[1] = newestValue(bus.readAddress2, bus.regData2, 1'b0);
      opsKnown = 1; immKnown = 1;
    end
  endtask

  task automatic checkModel();
    logic [63:0] a, sd;
    checkOutput("rnd.valid", bus.ex_valid, mValid);
    checkOutput("rnd.regWrite", bus.ex_regWrite, mRw);
    checkOutput("rnd.memRead", bus.ex_memRead, mMr);
    checkOutput("rnd.memWrite", bus.ex_memWrite, mMw);
    checkOutput("rnd.aluSrc", bus.ex_aluSrc, mAs);
    checkOutput("rnd.aluOp", bus.ex_aluOp, mOp);
    checkOutput("rnd.writeAddress", bus.ex_writeAddress, mWa);
    checkOutput("rnd.stall", bus.stall, modelStall());
    if (immKnown) checkOutput("rnd.imm", bus.ex_imm, mImm);
    if (opsKnown) begin
      a  = newestValue(mSrc[0], mVal[0], 1'b1);
      sd = newestValue(mSrc[1], mVal[1], 1'b1);
      checkOutput("rnd.operandA", bus.ex_operandA, a);
      checkOutput("rnd.storeData", bus.ex_storeData, sd);
      checkOutput("rnd.operandB", bus.ex_operandB, mAs ? mImm : sd);
    end
  endtask

  initial begin
    // Vector table: inputs held across one edge, outputs checked after it.
    v = '0; v.idValid = 1; v.ra1 = 1; v.rd1 = 16; v.ra2 = 2; v.rd2 = 12; v.wa = 6; v.regWrite = 1;
    v.expValid = 1; v.expRegWrite = 1; v.expWa = 6; v.chkOps = 1; v.expA = 16; v.expB = 12; tbl[0] = v;
    v = '0; v.idValid = 1; v.ra1 = 3; v.rd1 = 3; v.ra2 = 2; v.rd2 = 12; v.wa = 7; v.regWrite = 1;
    v.memRW = 1; v.memWA = 3; v.memRes = 99; v.wbRW = 1; v.wbWA = 3; v.wbData = 7;
    v.expValid = 1; v.expRegWrite = 1; v.expWa = 7; v.chkOps = 1; v.expA = 99; v.expB = 12; tbl[1] = v;
    v = '0; v.idValid = 1; v.ra1 = 8; v.rd1 = 80; v.ra2 = 9; v.rd2 = 90; v.aluSrc = 1;
    v.imm = 64'hFFFF_FFFF_FFFF_FFF8; v.wa = 10; v.regWrite = 1;
    v.expValid = 1; v.expRegWrite = 1; v.expWa = 10; v.chkOps = 1; v.expA = 80;
    v.expB = 64'hFFFF_FFFF_FFFF_FFF8; tbl[2] = v;
    v = '0; v.idValid = 1; v.ra1 = 31; v.ra2 = 31; v.wa = 1; v.regWrite = 1;
    v.memRW = 1; v.memWA = 31; v.memRes = 55; v.wbRW = 1; v.wbWA = 31; v.wbData = 66;
    v.expValid = 1; v.expRegWrite = 1; v.expWa = 1; v.chkOps = 1; v.expA = 0; v.expB = 0; tbl[3] = v;
    v = '0; v.idValid = 1; v.ra1 = 1; v.rd1 = 5; v.ra2 = 12; v.rd2 = 3; v.wa = 2; v.regWrite = 1;
    v.wbRW = 1; v.wbWA = 12; v.wbData = 64'h77;
    v.expValid = 1; v.expRegWrite = 1; v.expWa = 2; v.chkOps = 1; v.expA = 5; v.expB = 64'h77; tbl[4] = v;
    v = '0; v.idValid = 1; v.ra1 = 1; v.rd1 = 16; v.wa = 6; v.regWrite = 1; v.flush = 1;
    v.expValid = 0; v.expRegWrite = 0; v.expWa = 31; v.chkOps = 0; tbl[5] = v;
    v = '0; v.idValid = 0; v.ra1 = 11; v.rd1 = 21; v.ra2 = 12; v.rd2 = 22; v.wa = 9;
    v.regWrite = 1; v.memRead = 1;
    v.expValid = 0; v.expRegWrite = 0; v.expMemRead = 0; v.expWa = 9; v.chkOps = 1;
    v.expA = 21; v.expB = 22; tbl[6] = v;
    v = '0; v.idValid = 1; v.ra1 = 1; v.rd1 = 1; v.ra2 = 2; v.rd2 = 2; v.wa = 5;
    v.regWrite = 1; v.memRead = 1;
    v.expValid = 1; v.expRegWrite = 1; v.expMemRead = 1; v.expWa = 5; v.chkOps = 1;
    v.expA = 1; v.expB = 2; tbl[7] = v;

    // Reset held two cycles with a live, random decode slot.
    RESET = 1;
    clearInputs();
    bus.id_valid = 1; bus.readAddress1 = randReg(); bus.readAddress2 = randReg();
    bus.regData1 = rand64(); bus.regData2 = rand64(); bus.writeAddress = randReg();
    bus.id_imm = rand64(); bus.id_regWrite = 1; bus.id_memRead = 1; bus.id_memWrite = 1;
    bus.id_aluSrc = 1; bus.id_aluOp = 4'hF;
    tick(); tick();
    checkOutput("reset.valid", bus.ex_valid, 0);
    checkOutput("reset.ctrl", {bus.ex_regWrite, bus.ex_memRead, bus.ex_memWrite, bus.ex_aluSrc, bus.ex_aluOp}, 0);
    checkOutput("reset.writeAddress", bus.ex_writeAddress, 0);
    checkOutput("reset.imm", bus.ex_imm, 0);
    checkOutput("reset.stall", bus.stall, 0);
    clearInputs();
    #1;
    checkOutput("reset.operandA", bus.ex_operandA, 0);
    checkOutput("reset.storeData", bus.ex_storeData, 0);
    RESET = 0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i]);
      tick();
      checkOutput($sformatf("vec%0d.valid", i), bus.ex_valid, tbl[i].expValid);
      checkOutput($sformatf("vec%0d.regWrite", i), bus.ex_regWrite, tbl[i].expRegWrite);
      checkOutput($sformatf("vec%0d.memRead", i), bus.ex_memRead, tbl[i].expMemRead);
      checkOutput($sformatf("vec%0d.writeAddress", i), bus.ex_writeAddress, tbl[i].expWa);
      checkOutput($sformatf("vec%0d.stall", i), bus.stall, tbl[i].expStall);
      if (tbl[i].chkOps) begin
        checkOutput($sformatf("vec%0d.operandA", i), bus.ex_operandA, tbl[i].expA);
        checkOutput($sformatf("vec%0d.operandB", i), bus.ex_operandB, tbl[i].expB);
      end
    end

    // EX/MEM beats MEM/WB on the same register; removing each producer falls back in order.
    clearInputs();
    bus.id_valid = 1; bus.readAddress1 = 3; bus.regData1 = 3; bus.writeAddress = 2; bus.id_regWrite = 1;
    tick();
    bus.id_valid = 0;
    bus.mem_regWrite = 1; bus.mem_writeAddress = 3; bus.mem_result = 99;
    bus.wb_regWrite = 1; bus.wb_writeAddress = 3; bus.wb_writeData = 7;
    #1 checkOutput("dual.mem", bus.ex_operandA, 99);
    bus.mem_regWrite = 0;
    #1 checkOutput("dual.wb", bus.ex_operandA, 7);
    bus.wb_regWrite = 0;
    #1 checkOutput("dual.none", bus.ex_operandA, 3);

    // Load-use: one bubble, then the waiting consumer enters EX.
    clearInputs();
    bus.id_valid = 1; bus.id_memRead = 1; bus.id_regWrite = 1; bus.writeAddress = 5;
    tick();
    clearInputs();
    bus.id_valid = 1; bus.readAddress1 = 5; bus.regData1 = 50; bus.readAddress2 = 6;
    bus.regData2 = 60; bus.writeAddress = 7; bus.id_regWrite = 1;
    #1 checkOutput("loaduse.stall", bus.stall, 1);
    tick();
    checkOutput("loaduse.bubbleValid", bus.ex_valid, 0);
    checkOutput("loaduse.bubbleRegWrite", bus.ex_regWrite, 0);
    checkOutput("loaduse.stallReleased", bus.stall, 0);
    tick();
    checkOutput("loaduse.consumerValid", bus.ex_valid, 1);
    checkOutput("loaduse.consumerDest", bus.ex_writeAddress, 7);
    checkOutput("loaduse.consumerA", bus.ex_operandA, 50);

    // A load into XZR never stalls a reader of XZR.
    clearInputs();
    bus.id_valid = 1; bus.id_memRead = 1; bus.id_regWrite = 1; bus.writeAddress = 31;
    tick();
    clearInputs();
    bus.id_valid = 1; bus.readAddress1 = 31; bus.readAddress2 = 31;
    #1 checkOutput("xzr.noStall", bus.stall, 0);

    // Same-cycle register-file write is captured even after the WB producer leaves.
    clearInputs();
    bus.id_valid = 1; bus.readAddress1 = 4; bus.regData1 = 4;
    bus.wb_regWrite = 1; bus.wb_writeAddress = 4; bus.wb_writeData = 44;
    tick();
    bus.wb_regWrite = 0; bus.id_valid = 0;
    #1 checkOutput("bypass.operandA", bus.ex_operandA, 44);

    // Flush coincident with a load-use stall: stall still shows, bubble is loaded.
    clearInputs();
    bus.id_valid = 1; bus.id_memRead = 1; bus.id_regWrite = 1; bus.writeAddress = 5;
    tick();
    clearInputs();
    bus.id_valid = 1; bus.readAddress2 = 5; bus.writeAddress = 8; bus.id_regWrite = 1; bus.flush = 1;
    #1 checkOutput("flushStall.stall", bus.stall, 1);
    tick();
    checkOutput("flushStall.valid", bus.ex_valid, 0);
    checkOutput("flushStall.regWrite", bus.ex_regWrite, 0);
    checkOutput("flushStall.dest", bus.ex_writeAddress, 31);

    // Random traffic against the reference model, starting from reset.
    clearInputs();
    RESET = 1;
    @(posedge CLOCK);
    modelEdge();
    #1;
    for (int c = 0; c < 400; c++) begin
      RESET = ($urandom_range(0, 39) == 0);
      bus.id_valid = ($urandom_range(0, 4) != 0);
      bus.readAddress1 = randReg(); bus.readAddress2 = randReg();
      bus.regData1 = rand64(); bus.regData2 = rand64();
      bus.writeAddress = randReg(); bus.id_imm = rand64();
      bus.id_regWrite = 1'($urandom); bus.id_memRead = ($urandom_range(0, 2) == 0);
      bus.id_memWrite = 1'($urandom); bus.id_aluSrc = 1'($urandom); bus.id_aluOp = 4'($urandom);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.mem_regWrite = 1'($urandom); bus.mem_writeAddress = randReg(); bus.mem_result = rand64();
      bus.wb_regWrite = 1'($urandom); bus.wb_writeAddress = randReg(); bus.wb_writeData = rand64();
      #2;
      checkModel();
      @(posedge CLOCK);
      modelEdge();
      #1;
    end
    RESET = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
